// File: rtl/time_set_if.sv
// time_set_if: button/tick inputs and strobe/mode outputs of the time-setting controller.
// Signals: tick_1hz, btn_mode, btn_up, btn_down (to controller); mode, sec_en, sec_clr,
//          min_inc, min_dec, hr_inc, hr_dec, blink (from controller).
interface time_set_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [1:0] mode;
  logic       sec_en;
  logic       sec_clr;
  logic       min_inc;
  logic       min_dec;
  logic       hr_inc;
  logic       hr_dec;
  logic       blink;

  // master drives the tick and buttons and observes the controller outputs
  modport master (
    output tick_1hz, btn_mode, btn_up, btn_down,
    input  mode, sec_en, sec_clr, min_inc, min_dec, hr_inc, hr_dec, blink
  );

  // slave is the controller itself
  modport slave (
    input  tick_1hz, btn_mode, btn_up, btn_down,
    output mode, sec_en, sec_clr, min_inc, min_dec, hr_inc, hr_dec, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: RUN / SET_MIN / SET_HR clock-setting FSM with idle timeout and field blink.
// Ports: clk, reset (sync, active-low), bus (time_set_if.slave): tick/buttons in, strobes out.
// All outputs registered; each strobe is one cycle wide, one cycle after its cause.
module time_set_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic      clk,
  input  logic      reset,
  time_set_if.slave bus
);

  // encoding doubles as the mode output
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_HR  = 2'b10
  } state_t;

  state_t     state;
  logic [7:0] idle;
  logic       sec_en_q, sec_clr_q;
  logic       min_inc_q, min_dec_q, hr_inc_q, hr_dec_q;
  logic       blink_q;

  logic       adj_up, adj_dn, any_btn, timeout_hit;
  logic [8:0] idle_nxt;

  // up and down together cancel each other
  assign adj_up      = bus.btn_up & ~bus.btn_down;
  assign adj_dn      = bus.btn_down & ~bus.btn_up;
  assign any_btn     = bus.btn_mode | bus.btn_up | bus.btn_down;
  // the tick that would bring the idle count up to TIMEOUT is the one that exits
  assign idle_nxt    = {1'b0, idle} + 9'd1;
  assign timeout_hit = bus.tick_1hz && (idle_nxt == 9'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= RUN;
      idle      <= 8'd0;
      sec_en_q  <= 1'b0;
      sec_clr_q <= 1'b0;
      min_inc_q <= 1'b0;
      min_dec_q <= 1'b0;
      hr_inc_q  <= 1'b0;
      hr_dec_q  <= 1'b0;
      blink_q   <= 1'b0;
    end else begin
      sec_en_q  <= 1'b0;
      sec_clr_q <= 1'b0;
      min_inc_q <= 1'b0;
      min_dec_q <= 1'b0;
      hr_inc_q  <= 1'b0;
      hr_dec_q  <= 1'b0;
      case (state)
        RUN: begin
          idle    <= 8'd0;
          blink_q <= 1'b0;
          if (bus.btn_mode) begin
            // entering set: zero seconds, a coincident tick is dropped
            state     <= SET_MIN;
            sec_clr_q <= 1'b1;
            blink_q   <= 1'b1;
          end else if (bus.tick_1hz) begin
            sec_en_q <= 1'b1;
          end
        end
        SET_MIN, SET_HR: begin
          if (bus.btn_mode) begin
            // mode wins over adjust and over a coincident timeout
            idle <= 8'd0;
            if (state == SET_MIN) begin
              state   <= SET_HR;
              blink_q <= 1'b1;
            end else begin
              state   <= RUN;
              blink_q <= 1'b0;
            end
          end else if (any_btn) begin
            idle <= 8'd0;
            if (adj_up || adj_dn) begin
              blink_q <= 1'b1;
              if (state == SET_MIN) begin
                min_inc_q <= adj_up;
                min_dec_q <= adj_dn;
              end else begin
                hr_inc_q <= adj_up;
                hr_dec_q <= adj_dn;
              end
            end else if (bus.tick_1hz) begin
              blink_q <= ~blink_q;
            end
          end else if (bus.tick_1hz) begin
            if (timeout_hit) begin
              state   <= RUN;
              idle    <= 8'd0;
              blink_q <= 1'b0;
            end else begin
              idle    <= idle + 8'd1;
              blink_q <= ~blink_q;
            end
          end
        end
        default: begin
          state   <= RUN;
          idle    <= 8'd0;
          blink_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mode    = state;
  assign bus.sec_en  = sec_en_q;
  assign bus.sec_clr = sec_clr_q;
  assign bus.min_inc = min_inc_q;
  assign bus.min_dec = min_dec_q;
  assign bus.hr_inc  = hr_inc_q;
  assign bus.hr_dec  = hr_dec_q;
  assign bus.blink   = blink_q;

endmodule
